// File: rtl/except_ctrl.sv
// M-stage exception controller: prioritises exception/interrupt requests, captures
// EPC/BadVAddr/BD for CP0 and issues a one-cycle flush/redirect pulse.
module except_ctrl #(
    parameter int          N_EXT       = 6,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] EXC_VEC     = 32'hBFC00380
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [N_EXT-1:0] ext_int,
    input  logic             stallM,
    input  logic [31:0]      cp0_status,
    input  logic [31:0]      cp0_cause,
    input  logic [31:0]      cp0_epc,
    input  logic [31:0]      pcM,
    input  logic [31:0]      bad_addrM,
    input  logic             in_dsM,
    input  logic             is_syscallM,
    input  logic             is_breakM,
    input  logic             is_eretM,
    input  logic             is_AdEL_pcM,
    input  logic             is_AdEL_dataM,
    input  logic             is_AdESM,
    input  logic             is_overflowM,
    input  logic             is_invalidM,
    output logic             except_detM,
    output logic             except_valid,
    output logic [31:0]      except_pc,
    output logic [4:0]       except_code,
    output logic             except_eret,
    output logic [31:0]      except_epc,
    output logic [31:0]      except_badvaddr,
    output logic             except_bd,
    output logic             except_has_badv
);

    // state | meaning
    // IDLE  | watching for requests
    // HOLD  | request captured, waiting for the memory stall to clear
    // FLUSH | except_valid pulse cycle
    // BLOCK | one-cycle blanking after the flush
    typedef enum logic [1:0] {IDLE, HOLD, FLUSH, BLOCK} state_t;

    localparam logic [4:0] CODE_INT  = 5'h00;
    localparam logic [4:0] CODE_ADEL = 5'h04;
    localparam logic [4:0] CODE_ADES = 5'h05;
    localparam logic [4:0] CODE_SYS  = 5'h08;
    localparam logic [4:0] CODE_BP   = 5'h09;
    localparam logic [4:0] CODE_RI   = 5'h0A;
    localparam logic [4:0] CODE_OV   = 5'h0C;

    state_t           state, state_n;
    logic [N_EXT-1:0] sync_q [SYNC_STAGES];
    logic [5:0]       ext_pad;
    logic             int_req;
    logic             any_req;
    logic             det;
    logic             capture;
    logic [4:0]       code_n;
    logic             eret_n;
    logic [31:0]      badv_n;
    logic             has_badv_n;
    logic             unused_bits;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= ext_int;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    always_comb begin
        ext_pad = '0;
        ext_pad[N_EXT-1:0] = sync_q[SYNC_STAGES-1];
    end

    assign int_req = (|(cp0_status[15:8] & {ext_pad, cp0_cause[9:8]}))
                     & cp0_status[0] & ~cp0_status[1];

    assign unused_bits = ^{cp0_status[31:16], cp0_status[7:2],
                           cp0_cause[31:10], cp0_cause[7:0]};

    always_comb begin
        code_n     = CODE_INT;
        eret_n     = 1'b0;
        badv_n     = '0;
        has_badv_n = 1'b0;
        any_req    = 1'b1;
        if (int_req) begin
            code_n = CODE_INT;
        end else if (is_AdEL_pcM) begin
            code_n     = CODE_ADEL;
            badv_n     = pcM;
            has_badv_n = 1'b1;
        end else if (is_AdEL_dataM) begin
            code_n     = CODE_ADEL;
            badv_n     = bad_addrM;
            has_badv_n = 1'b1;
        end else if (is_AdESM) begin
            code_n     = CODE_ADES;
            badv_n     = bad_addrM;
            has_badv_n = 1'b1;
        end else if (is_syscallM) begin
            code_n = CODE_SYS;
        end else if (is_breakM) begin
            code_n = CODE_BP;
        end else if (is_invalidM) begin
            code_n = CODE_RI;
        end else if (is_overflowM) begin
            code_n = CODE_OV;
        end else if (is_eretM) begin
            eret_n = 1'b1;
        end else begin
            any_req = 1'b0;
        end
    end

    // Gated by resetn so nothing is blocked from committing while in reset.
    assign det         = resetn & any_req & (state == IDLE);
    assign except_detM = det;

    always_comb begin
        state_n = state;
        capture = 1'b0;
        case (state)
            IDLE: begin
                if (det) begin
                    capture = 1'b1;
                    state_n = stallM ? HOLD : FLUSH;
                end
            end
            HOLD:    if (!stallM) state_n = FLUSH;
            FLUSH:   state_n = BLOCK;
            BLOCK:   state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state           <= IDLE;
            except_valid    <= 1'b0;
            except_pc       <= '0;
            except_code     <= '0;
            except_eret     <= 1'b0;
            except_epc      <= '0;
            except_badvaddr <= '0;
            except_bd       <= 1'b0;
            except_has_badv <= 1'b0;
        end else begin
            state        <= state_n;
            except_valid <= (state_n == FLUSH);
            if (capture) begin
                except_pc       <= eret_n ? cp0_epc : EXC_VEC;
                except_code     <= code_n;
                except_eret     <= eret_n;
                except_epc      <= in_dsM ? (pcM - 32'd4) : pcM;
                except_badvaddr <= badv_n;
                except_bd       <= in_dsM;
                except_has_badv <= has_badv_n;
            end
        end
    end

endmodule

// File: tb/tb_except_ctrl.sv
// Directed bench for except_ctrl: table of single-flush vectors plus hand-written
// sequences for reset, stall hold, interrupts and back-to-back events.
module tb_except_ctrl;

    localparam int N_EXT = 6;
    localparam int SYNC  = 2;

    localparam logic [7:0] F_SYS    = 8'h01;
    localparam logic [7:0] F_BRK    = 8'h02;
    localparam logic [7:0] F_ERET   = 8'h04;
    localparam logic [7:0] F_ADELPC = 8'h08;
    localparam logic [7:0] F_ADELD  = 8'h10;
    localparam logic [7:0] F_ADES   = 8'h20;
    localparam logic [7:0] F_OV     = 8'h40;
    localparam logic [7:0] F_RI     = 8'h80;

    logic             clk = 1'b0;
    logic             resetn;
    logic [N_EXT-1:0] ext_int;
    logic             stallM;
    logic [31:0]      cp0_status, cp0_cause, cp0_epc, pcM, bad_addrM;
    logic             in_dsM;
    logic [7:0]       flags;
    logic             except_detM, except_valid, except_eret, except_bd, except_has_badv;
    logic [31:0]      except_pc, except_epc, except_badvaddr;
    logic [4:0]       except_code;

    int n_checks = 0;
    int n_bad    = 0;

    typedef struct {
        logic [7:0]  flags;
        logic [31:0] pc;
        logic [31:0] bad;
        logic        ds;
        logic [31:0] epc_in;
        logic [4:0]  code;
        logic        eret;
        logic [31:0] epc;
        logic [31:0] badv;
        logic        has_badv;
        logic [31:0] tgt;
    } vec_t;

    vec_t vecs [9];

    always #5 clk = ~clk;

    except_ctrl #(.N_EXT(N_EXT), .SYNC_STAGES(SYNC), .EXC_VEC(32'hBFC00380)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .ext_int         (ext_int),
        .stallM          (stallM),
        .cp0_status      (cp0_status),
        .cp0_cause       (cp0_cause),
        .cp0_epc         (cp0_epc),
        .pcM             (pcM),
        .bad_addrM       (bad_addrM),
        .in_dsM          (in_dsM),
        .is_syscallM     (flags[0]),
        .is_breakM       (flags[1]),
        .is_eretM        (flags[2]),
        .is_AdEL_pcM     (flags[3]),
        .is_AdEL_dataM   (flags[4]),
        .is_AdESM        (flags[5]),
        .is_overflowM    (flags[6]),
        .is_invalidM     (flags[7]),
        .except_detM     (except_detM),
        .except_valid    (except_valid),
        .except_pc       (except_pc),
        .except_code     (except_code),
        .except_eret     (except_eret),
        .except_epc      (except_epc),
        .except_badvaddr (except_badvaddr),
        .except_bd       (except_bd),
        .except_has_badv (except_has_badv)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{F_OV, 32'h80001000, 32'h0, 1'b1, 32'h0,
                    5'h0C, 1'b0, 32'h80000FFC, 32'h0, 1'b0, 32'hBFC00380};
        vecs[1] = '{F_ADELPC | F_ADELD | F_SYS, 32'h00400003, 32'h10000002, 1'b0, 32'h0,
                    5'h04, 1'b0, 32'h00400003, 32'h00400003, 1'b1, 32'hBFC00380};
        vecs[2] = '{F_ADELD | F_ADES, 32'h00400010, 32'h10000005, 1'b1, 32'h0,
                    5'h04, 1'b0, 32'h0040000C, 32'h10000005, 1'b1, 32'hBFC00380};
        vecs[3] = '{F_ADES | F_SYS | F_OV, 32'h00400020, 32'h2000000A, 1'b0, 32'h0,
                    5'h05, 1'b0, 32'h00400020, 32'h2000000A, 1'b1, 32'hBFC00380};
        vecs[4] = '{F_SYS | F_BRK | F_ERET, 32'h00400030, 32'h0, 1'b0, 32'h0,
                    5'h08, 1'b0, 32'h00400030, 32'h0, 1'b0, 32'hBFC00380};
        vecs[5] = '{F_BRK | F_RI, 32'h00400040, 32'h0, 1'b0, 32'h0,
                    5'h09, 1'b0, 32'h00400040, 32'h0, 1'b0, 32'hBFC00380};
        vecs[6] = '{F_RI | F_OV | F_ERET, 32'h00400050, 32'h0, 1'b0, 32'h0,
                    5'h0A, 1'b0, 32'h00400050, 32'h0, 1'b0, 32'hBFC00380};
        vecs[7] = '{F_ERET, 32'h00400060, 32'h0, 1'b0, 32'hBFC00704,
                    5'h00, 1'b1, 32'h00400060, 32'h0, 1'b0, 32'hBFC00704};
        vecs[8] = '{F_SYS, 32'h00000000, 32'h0, 1'b1, 32'h0,
                    5'h08, 1'b0, 32'hFFFFFFFC, 32'h0, 1'b0, 32'hBFC00380};

        resetn     = 1'b0;
        ext_int    = '0;
        stallM     = 1'b0;
        cp0_status = 32'h0;
        cp0_cause  = 32'h0;
        cp0_epc    = 32'h0;
        pcM        = 32'h80000000;
        bad_addrM  = 32'h0;
        in_dsM     = 1'b1;
        flags      = 8'hFF;

        // reset with every flag raised
        repeat (3) tick();
        check("rst_detM", {31'b0, except_detM}, 32'h0);
        check("rst_valid", {31'b0, except_valid}, 32'h0);
        check("rst_pc", except_pc, 32'h0);
        check("rst_code", {27'b0, except_code}, 32'h0);
        check("rst_eret", {31'b0, except_eret}, 32'h0);
        check("rst_epc", except_epc, 32'h0);
        check("rst_badv", except_badvaddr, 32'h0);
        check("rst_bd", {31'b0, except_bd}, 32'h0);
        check("rst_has_badv", {31'b0, except_has_badv}, 32'h0);
        flags  = 8'h0;
        in_dsM = 1'b0;
        resetn = 1'b1;
        tick();
        check("idle_detM", {31'b0, except_detM}, 32'h0);
        check("idle_valid", {31'b0, except_valid}, 32'h0);

        for (int i = 0; i < 9; i++) begin
            tick();
            flags     = vecs[i].flags;
            pcM       = vecs[i].pc;
            bad_addrM = vecs[i].bad;
            in_dsM    = vecs[i].ds;
            cp0_epc   = vecs[i].epc_in;
            #1;
            check($sformatf("v%0d_detM", i), {31'b0, except_detM}, 32'h1);
            tick();
            check($sformatf("v%0d_valid", i), {31'b0, except_valid}, 32'h1);
            check($sformatf("v%0d_code", i), {27'b0, except_code}, {27'b0, vecs[i].code});
            check($sformatf("v%0d_eret", i), {31'b0, except_eret}, {31'b0, vecs[i].eret});
            check($sformatf("v%0d_epc", i), except_epc, vecs[i].epc);
            check($sformatf("v%0d_bd", i), {31'b0, except_bd}, {31'b0, vecs[i].ds});
            check($sformatf("v%0d_has_badv", i), {31'b0, except_has_badv}, {31'b0, vecs[i].has_badv});
            if (vecs[i].has_badv)
                check($sformatf("v%0d_badv", i), except_badvaddr, vecs[i].badv);
            check($sformatf("v%0d_pc", i), except_pc, vecs[i].tgt);
            flags = 8'h0;
            tick();
            check($sformatf("v%0d_valid_after", i), {31'b0, except_valid}, 32'h0);
            check($sformatf("v%0d_block_detM", i), {31'b0, except_detM}, 32'h0);
        end

        // AdES + syscall held under a 4-cycle stall
        tick();
        flags     = F_ADES | F_SYS;
        pcM       = 32'h00400100;
        bad_addrM = 32'h12345671;
        in_dsM    = 1'b0;
        stallM    = 1'b1;
        #1;
        check("stall_detM", {31'b0, except_detM}, 32'h1);
        for (int k = 1; k <= 3; k++) begin
            tick();
            check($sformatf("stall_valid_%0d", k), {31'b0, except_valid}, 32'h0);
            check($sformatf("stall_hold_detM_%0d", k), {31'b0, except_detM}, 32'h0);
        end
        tick();
        stallM = 1'b0;
        #1;
        check("stall_fall_valid", {31'b0, except_valid}, 32'h0);
        tick();
        check("stall_pulse", {31'b0, except_valid}, 32'h1);
        check("stall_code", {27'b0, except_code}, 32'h5);
        check("stall_badv", except_badvaddr, 32'h12345671);
        check("stall_has_badv", {31'b0, except_has_badv}, 32'h1);
        flags = 8'h0;
        tick();
        check("stall_after", {31'b0, except_valid}, 32'h0);
        check("stall_keep_code", {27'b0, except_code}, 32'h5);

        // hardware interrupt on line 5
        tick();
        cp0_status = 32'h00008401;
        pcM        = 32'h80002000;
        ext_int[5] = 1'b1;
        #1;
        check("int_det_t0", {31'b0, except_detM}, 32'h0);
        repeat (SYNC - 1) tick();
        check("int_det_early", {31'b0, except_detM}, 32'h0);
        tick();
        check("int_det", {31'b0, except_detM}, 32'h1);
        tick();
        check("int_valid", {31'b0, except_valid}, 32'h1);
        check("int_code", {27'b0, except_code}, 32'h0);
        check("int_eret", {31'b0, except_eret}, 32'h0);
        check("int_epc", except_epc, 32'h80002000);
        ext_int    = '0;
        cp0_status = 32'h0;
        repeat (3) tick();

        // EXL set masks the interrupt
        cp0_status = 32'h00008403;
        ext_int[5] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("exl_detM_%0d", k), {31'b0, except_detM}, 32'h0);
            check($sformatf("exl_valid_%0d", k), {31'b0, except_valid}, 32'h0);
        end
        ext_int    = '0;
        cp0_status = 32'h0;
        repeat (3) tick();

        // break held continuously
        tick();
        flags = F_BRK;
        pcM   = 32'h00400200;
        #1;
        check("b2b_detM", {31'b0, except_detM}, 32'h1);
        for (int k = 1; k <= 9; k++) begin
            tick();
            check($sformatf("b2b_valid_%0d", k), {31'b0, except_valid}, {31'b0, (k % 3) == 1});
            if ((k % 3) == 1)
                check($sformatf("b2b_code_%0d", k), {27'b0, except_code}, 32'h9);
        end
        flags = 8'h0;
        repeat (3) tick();

        // reset while holding a stalled syscall
        tick();
        flags  = F_SYS;
        pcM    = 32'h80003000;
        stallM = 1'b1;
        #1;
        check("rh_detM", {31'b0, except_detM}, 32'h1);
        tick();
        check("rh_hold_valid", {31'b0, except_valid}, 32'h0);
        resetn = 1'b0;
        tick();
        check("rh_rst_code", {27'b0, except_code}, 32'h0);
        check("rh_rst_epc", except_epc, 32'h0);
        resetn = 1'b1;
        stallM = 1'b0;
        flags  = 8'h0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("rh_valid_%0d", k), {31'b0, except_valid}, 32'h0);
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
